// File: rtl/cpu_isa_pkg.sv
// ----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared instruction-set definitions for the CPU control decoder and the
// program loader:
//   - one-hot bit positions of the operation select bus
//   - 4-bit opcode values
//   - IR field positions ([7:4] opcode, [3:0] operand)
//   - the loader FSM state type
//   - pure helpers: one-hot check and instruction encoding
// Opcode 0xF is unused by the ISA. Inside the loader it marks an entry that
// only ends a program and is never written to RAM.
// ----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam int OP_W  = 11;
    localparam int IR_W  = 8;

    // IR field positions
    localparam int IR_OPC_MSB = 7;
    localparam int IR_OPC_LSB = 4;
    localparam int IR_OPD_MSB = 3;
    localparam int IR_OPD_LSB = 0;

    // One-hot select bit indices on in_op
    localparam int OP_BIT_LOAD   = 0;
    localparam int OP_BIT_ADD    = 1;
    localparam int OP_BIT_SUB    = 2;
    localparam int OP_BIT_BITAND = 3;
    localparam int OP_BIT_IP     = 4;
    localparam int OP_BIT_OP     = 5;
    localparam int OP_BIT_JUMP   = 6;
    localparam int OP_BIT_JUMPZ  = 7;
    localparam int OP_BIT_JUMPNZ = 8;
    localparam int OP_BIT_JUMPC  = 9;
    localparam int OP_BIT_JUMPNC = 10;

    // Opcodes as stored in IR[7:4]
    localparam logic [3:0] OPC_LOAD   = 4'h0;
    localparam logic [3:0] OPC_ADD    = 4'h1;
    localparam logic [3:0] OPC_SUB    = 4'h2;
    localparam logic [3:0] OPC_BITAND = 4'h3;
    localparam logic [3:0] OPC_IP     = 4'h4;
    localparam logic [3:0] OPC_OP     = 4'h5;
    localparam logic [3:0] OPC_JUMP   = 4'h6;
    localparam logic [3:0] OPC_JUMPZ  = 4'h7;
    localparam logic [3:0] OPC_JUMPNZ = 4'h8;
    localparam logic [3:0] OPC_JUMPC  = 4'h9;
    localparam logic [3:0] OPC_JUMPNC = 4'hA;
    localparam logic [3:0] OPC_MARKER = 4'hF;

    localparam logic [IR_W-1:0] IR_MARKER = 8'hF0;

    // One-hot select patterns
    localparam logic [OP_W-1:0] SEL_LOAD   = 11'b1 << OP_BIT_LOAD;
    localparam logic [OP_W-1:0] SEL_ADD    = 11'b1 << OP_BIT_ADD;
    localparam logic [OP_W-1:0] SEL_SUB    = 11'b1 << OP_BIT_SUB;
    localparam logic [OP_W-1:0] SEL_BITAND = 11'b1 << OP_BIT_BITAND;
    localparam logic [OP_W-1:0] SEL_IP     = 11'b1 << OP_BIT_IP;
    localparam logic [OP_W-1:0] SEL_OP     = 11'b1 << OP_BIT_OP;
    localparam logic [OP_W-1:0] SEL_JUMP   = 11'b1 << OP_BIT_JUMP;
    localparam logic [OP_W-1:0] SEL_JUMPZ  = 11'b1 << OP_BIT_JUMPZ;
    localparam logic [OP_W-1:0] SEL_JUMPNZ = 11'b1 << OP_BIT_JUMPNZ;
    localparam logic [OP_W-1:0] SEL_JUMPC  = 11'b1 << OP_BIT_JUMPC;
    localparam logic [OP_W-1:0] SEL_JUMPNC = 11'b1 << OP_BIT_JUMPNC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DONE    = 2'd2
    } loader_state_e;

    // True when exactly one select bit is set
    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != {OP_W{1'b0}}) &&
               ((op & (op - {{(OP_W-1){1'b0}}, 1'b1})) == {OP_W{1'b0}});
    endfunction

    // Builds the IR byte; a non-one-hot select yields the marker opcode
    function automatic logic [IR_W-1:0] encode_ir(input logic [OP_W-1:0] op,
                                                  input logic [3:0]      operand);
        logic [3:0]      opc;
        logic [IR_W-1:0] ir;
        case (op)
            SEL_LOAD:   opc = OPC_LOAD;
            SEL_ADD:    opc = OPC_ADD;
            SEL_SUB:    opc = OPC_SUB;
            SEL_BITAND: opc = OPC_BITAND;
            SEL_IP:     opc = OPC_IP;
            SEL_OP:     opc = OPC_OP;
            SEL_JUMP:   opc = OPC_JUMP;
            SEL_JUMPZ:  opc = OPC_JUMPZ;
            SEL_JUMPNZ: opc = OPC_JUMPNZ;
            SEL_JUMPC:  opc = OPC_JUMPC;
            SEL_JUMPNC: opc = OPC_JUMPNC;
            default:    opc = OPC_MARKER;
        endcase
        ir[IR_OPC_MSB:IR_OPC_LSB] = opc;
        ir[IR_OPD_MSB:IR_OPD_LSB] = operand;
        return ir;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// ----------------------------------------------------------------------------
// loader_fifo
// Synchronous FIFO, first-word-fall-through read (pop_data shows the head).
//   clock     : rising-edge clock
//   clear     : synchronous active-high clear, empties the FIFO
//   push      : write push_data (ignored while full)
//   pop       : drop the head entry (ignored while empty)
//   push_data : entry to store
//   pop_data  : current head entry
//   full      : no free slot
//   empty     : no stored entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ----------------------------------------------------------------------------
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = store_r[rd_ptr_r[PTR_W-1:0]];

    // Pointer update
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because pointers gate reads
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            store_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Encodes one-hot instructions into 8-bit IR words, buffers them and writes
// them sequentially into program RAM while holding the CPU in clear.
//   clock, clear          : clock and synchronous active-high reset
//   in_valid/in_ready     : producer handshake, beat accepted when both high
//   in_op, in_operand     : one-hot operation select and 4-bit operand
//   in_last               : last instruction of the program
//   mem_we/addr/wdata     : program RAM write port
//   cpu_hold              : CPU clear while a load is in progress
//   load_done             : one-cycle pulse at load completion
//   err_invalid           : sticky, non-one-hot select accepted
//   err_overflow          : sticky, program longer than 2^ADDR_W words
// The RAM write port is registered: an entry popped in one cycle appears on
// mem_we in the following cycle, so the final write coincides with DONE.
// ----------------------------------------------------------------------------
module program_loader
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_op,
    input  logic [3:0]        in_operand,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err_invalid,
    output logic              err_overflow
);
    localparam int                FIFO_W   = IR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    loader_state_e     state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              discard_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [IR_W-1:0]   mem_wdata_r;
    logic              cpu_hold_r;
    logic              load_done_r;
    logic              err_invalid_r;
    logic              err_overflow_r;

    logic              accept_s;
    logic              beat_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FIFO_W-1:0] push_entry_s;
    logic [FIFO_W-1:0] pop_entry_s;
    logic              entry_last_s;
    logic              entry_marker_s;

    assign in_ready     = !clear && !fifo_full_s && (state_r != ST_DONE);
    assign accept_s     = in_valid && in_ready;
    assign beat_valid_s = op_is_onehot(in_op);
    // Invalid beats are dropped unless they carry last, which survives as a marker
    assign push_s       = accept_s && (beat_valid_s || in_last);
    assign pop_s        = (state_r == ST_LOADING) && !fifo_empty_s;

    assign entry_last_s   = pop_entry_s[IR_W];
    assign entry_marker_s = (pop_entry_s[IR_OPC_MSB:IR_OPC_LSB] == OPC_MARKER);

    // FIFO entry: {last, IR}, or a last-only marker for an invalid final beat
    always_comb begin
        push_entry_s = {1'b1, IR_MARKER};
        if (beat_valid_s) begin
            push_entry_s = {in_last, encode_ir(in_op, in_operand)};
        end else begin
            push_entry_s = {1'b1, IR_MARKER};
        end
    end

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_entry_s),
        .pop_data  (pop_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Load sequencing FSM with registered RAM port, hold, done and error flags
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r        <= ST_IDLE;
            wr_ptr_r       <= {ADDR_W{1'b0}};
            discard_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= 8'h00;
            cpu_hold_r     <= 1'b0;
            load_done_r    <= 1'b0;
            err_invalid_r  <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            mem_we_r    <= 1'b0;
            load_done_r <= 1'b0;
            if (accept_s && !beat_valid_s) begin
                err_invalid_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    // Leftover entries also restart a load so they cannot stall
                    if (accept_s || !fifo_empty_s) begin
                        state_r    <= ST_LOADING;
                        cpu_hold_r <= 1'b1;
                        wr_ptr_r   <= {ADDR_W{1'b0}};
                        mem_addr_r <= {ADDR_W{1'b0}};
                        discard_r  <= 1'b0;
                    end
                end
                ST_LOADING: begin
                    if (pop_s) begin
                        if (!discard_r && !entry_marker_s) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= wr_ptr_r;
                            mem_wdata_r <= pop_entry_s[IR_W-1:0];
                            // Top address without last: flag and drain the rest
                            if (wr_ptr_r == ADDR_MAX) begin
                                if (!entry_last_s) begin
                                    discard_r      <= 1'b1;
                                    err_overflow_r <= 1'b1;
                                end
                            end else begin
                                wr_ptr_r <= wr_ptr_r + 1'b1;
                            end
                        end
                        if (entry_last_s) begin
                            state_r     <= ST_DONE;
                            load_done_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    cpu_hold_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cpu_hold_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign err_invalid  = err_invalid_r;
    assign err_overflow = err_overflow_r;

endmodule
